// File: rtl/fu_result_arbiter.sv
// rtl/fu_result_arbiter.sv - per-unit result holding slots, round-robin onto one CDB port
// Each slot holds one unwritten result; slot_busy lets issue logic avoid overrunning a slot.
module fu_result_arbiter #(
   parameter int NUM_FU = 4,
   parameter int TAG_W  = 5,
   parameter int SRC_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_FU-1:0]       fu_finish,
   input  logic [NUM_FU*32-1:0]    fu_res,
   input  logic [NUM_FU*TAG_W-1:0] fu_tag,
   output logic                    cdb_valid,
   output logic [31:0]             cdb_data,
   output logic [TAG_W-1:0]        cdb_tag,
   output logic [SRC_W-1:0]        cdb_src,
   input  logic                    cdb_ready,
   output logic [NUM_FU-1:0]       slot_busy,
   output logic                    overflow
);

   logic [NUM_FU-1:0]             full_q, full_d;
   logic [NUM_FU-1:0][31:0]       data_q, data_d;
   logic [NUM_FU-1:0][TAG_W-1:0]  tag_q, tag_d;
   logic [SRC_W-1:0]              rr_q, rr_d;
   logic                          overflow_q, overflow_d;
   logic [SRC_W-1:0]              grant;
   logic                          found;
   logic                          xfer;

   // First full slot at or after rr, wrapping; depends only on registered state.
   always_comb begin : grant_search
      int idx;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_FU) idx = idx - NUM_FU;
         if (!found && full_q[idx]) begin
            found = 1'b1;
            grant = SRC_W'(idx);
         end
      end
   end

   assign xfer      = found & cdb_ready;
   assign cdb_valid = found;
   assign cdb_data  = found ? data_q[grant] : 32'd0;
   assign cdb_tag   = found ? tag_q[grant]  : '0;
   assign cdb_src   = found ? grant         : '0;
   assign slot_busy = full_q;
   assign overflow  = overflow_q;

   always_comb begin : next_state
      int   nxt;
      logic drain;
      full_d     = full_q;
      data_d     = data_q;
      tag_d      = tag_q;
      overflow_d = overflow_q;
      rr_d       = rr_q;
      nxt        = 0;
      drain      = 1'b0;
      if (xfer) begin
         nxt = int'(grant) + 1;
         if (nxt >= NUM_FU) nxt = 0;
         rr_d = SRC_W'(nxt);
      end
      for (int i = 0; i < NUM_FU; i++) begin
         drain = xfer && (int'(grant) == i);
         if (drain) full_d[i] = 1'b0;
         // A slot being drained on this edge may be refilled on the same edge.
         if (fu_finish[i]) begin
            if (!full_q[i] || drain) begin
               full_d[i] = 1'b1;
               data_d[i] = fu_res[32*i +: 32];
               tag_d[i]  = fu_tag[TAG_W*i +: TAG_W];
            end else begin
               overflow_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q     <= '0;
         data_q     <= '0;
         tag_q      <= '0;
         rr_q       <= '0;
         overflow_q <= 1'b0;
      end else begin
         full_q     <= full_d;
         data_q     <= data_d;
         tag_q      <= tag_d;
         rr_q       <= rr_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_fu_result_arbiter.sv
// tb/tb_fu_result_arbiter.sv - directed self-checking bench for fu_result_arbiter
module tb_fu_result_arbiter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   fu_finish = '0;
   logic [127:0] fu_res = '0;
   logic [19:0]  fu_tag = '0;
   logic         cdb_valid;
   logic [31:0]  cdb_data;
   logic [4:0]   cdb_tag;
   logic [1:0]   cdb_src;
   logic         cdb_ready = 1'b0;
   logic [3:0]   slot_busy;
   logic         overflow;

   int tests_run = 0;
   int tests_failed = 0;

   fu_result_arbiter #(.NUM_FU(4), .TAG_W(5), .SRC_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .fu_finish(fu_finish), .fu_res(fu_res), .fu_tag(fu_tag),
      .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_tag(cdb_tag),
      .cdb_src(cdb_src), .cdb_ready(cdb_ready),
      .slot_busy(slot_busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fu_finish = '0;
      cdb_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic load(input int u, input logic [31:0] res, input logic [4:0] tg);
      fu_finish[u] = 1'b1;
      fu_res[32*u +: 32] = res;
      fu_tag[5*u +: 5] = tg;
   endtask

   logic [1:0] exp_src;

   initial begin
      do_reset();
      check("rst_valid", cdb_valid, 0);
      check("rst_busy", slot_busy, 0);
      check("rst_ovf", overflow, 0);
      check("rst_data", cdb_data, 0);

      // single result from unit 2
      cdb_ready = 1'b1;
      load(2, 32'h7, 5'd3);
      #1;
      check("no_comb_path", cdb_valid, 0);
      tick();
      fu_finish = '0;
      check("s_valid", cdb_valid, 1);
      check("s_data", cdb_data, 32'h7);
      check("s_tag", cdb_tag, 3);
      check("s_src", cdb_src, 2);
      check("s_busy", slot_busy, 4'b0100);
      tick();
      check("s_valid_after", cdb_valid, 0);
      check("s_busy_after", slot_busy, 0);

      // all four at once, rr = 0
      do_reset();
      cdb_ready = 1'b1;
      for (int i = 0; i < 4; i++) load(i, 32'h10 + i, 5'(i + 8));
      tick();
      fu_finish = '0;
      for (int i = 0; i < 4; i++) begin
         check("all_src", cdb_src, i);
         check("all_data", cdb_data, 32'h10 + i);
         check("all_tag", cdb_tag, i + 8);
         check("all_busy", slot_busy, (4'b1111 << i) & 4'b1111);
         tick();
      end
      check("all_empty", cdb_valid, 0);

      // fairness: refill the drained slot on every edge
      load(0, 32'h100, 5'd1);
      load(1, 32'h200, 5'd2);
      tick();
      fu_finish = '0;
      exp_src = 2'd0;
      for (int n = 0; n < 6; n++) begin
         check("fair_src", cdb_src, exp_src);
         check("fair_busy", slot_busy, 4'b0011);
         fu_finish = '0;
         load(int'(exp_src), 32'h300 + n, 5'd4);
         tick();
         exp_src = (exp_src == 2'd0) ? 2'd1 : 2'd0;
      end
      fu_finish = '0;
      repeat (2) tick();
      check("fair_drained", cdb_valid, 0);

      // stall with slot 3 held, then drain + refill on the same edge
      do_reset();
      load(3, 32'hDEAD_BEEF, 5'd7);
      tick();
      fu_finish = '0;
      for (int n = 0; n < 5; n++) begin
         check("stall_valid", cdb_valid, 1);
         check("stall_data", cdb_data, 32'hDEAD_BEEF);
         check("stall_src", cdb_src, 3);
         tick();
      end
      cdb_ready = 1'b1;
      load(3, 32'h1, 5'd9);
      tick();
      fu_finish = '0;
      cdb_ready = 1'b0;
      check("refill_valid", cdb_valid, 1);
      check("refill_data", cdb_data, 32'h1);
      check("refill_tag", cdb_tag, 9);
      check("refill_busy", slot_busy, 4'b1000);
      cdb_ready = 1'b1;
      tick();
      cdb_ready = 1'b0;
      check("one_xfer_empty", cdb_valid, 0);

      // overflow on a full, undrained slot
      do_reset();
      load(1, 32'hA, 5'd5);
      tick();
      load(1, 32'hB, 5'd6);
      tick();
      fu_finish = '0;
      check("ovf_set", overflow, 1);
      check("ovf_kept_data", cdb_data, 32'hA);
      check("ovf_kept_src", cdb_src, 1);
      cdb_ready = 1'b1;
      tick();
      check("ovf_drain_empty", cdb_valid, 0);
      check("ovf_sticky", overflow, 1);
      load(2, 32'h55, 5'd2);
      tick();
      fu_finish = '0;
      check("mid_valid", cdb_valid, 1);
      rst_n = 1'b0;
      #2;
      check("async_valid", cdb_valid, 0);
      check("async_busy", slot_busy, 0);
      check("async_ovf", overflow, 0);
      check("async_data", cdb_data, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_valid", cdb_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1);
   end

endmodule
